// File: rtl/pong_pkg.sv
// Shared types and widths for the pong game sequencer and its frame timer.
package pong_pkg;

    typedef enum logic [3:0] {
        ATTRACT,
        NEW_GAME,
        POSITION,
        READY,
        COUNTDOWN,
        PLAY,
        PAUSE,
        POINT,
        END_GAME
    } game_state_t;

    localparam int SCOREW = 4;
    localparam int TIMERW = 16;

endpackage

// File: rtl/pong_frame_timer.sv
// Counts frame pulses since the last clear and flags the frame that completes a runtime limit.
module pong_frame_timer
    import pong_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_frame,
    input  logic [TIMERW-1:0] i_limit,
    output logic              o_done
);

    logic [TIMERW-1:0] r_fcnt;
    logic [TIMERW-1:0] w_last;

    assign w_last = i_limit - TIMERW'(1);
    assign o_done = i_frame && (r_fcnt == w_last);

    // A clear wins over a coincident frame so every new interval starts from zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fcnt <= '0;
        end else if (i_clr) begin
            r_fcnt <= '0;
        end else if (i_frame) begin
            r_fcnt <= r_fcnt + TIMERW'(1);
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: state machine, scores, serve side, countdown and datapath strobes.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN        = 4,
    parameter int FPS        = 60,
    parameter int COUNT_SEC  = 3,
    parameter int READY_WAIT = 300,
    parameter int POINT_WAIT = 90,
    parameter int END_WAIT   = 600
) (
    input  logic              clk_pix,
    input  logic              rst_pix,
    input  logic              frame,
    input  logic              sig_fire,
    input  logic              sig_pause,
    input  logic              coll_l,
    input  logic              coll_r,
    output game_state_t       state,
    output logic [SCOREW-1:0] score_l,
    output logic [SCOREW-1:0] score_r,
    output logic              pos_stb,
    output logic              play_en,
    output logic              serve_r,
    output logic [3:0]        count,
    output logic              winner_r,
    output logic              attract
);

    localparam logic [SCOREW-1:0] W_WIN = SCOREW'(WIN);

    game_state_t       r_state;
    game_state_t       w_next;
    logic [SCOREW-1:0] r_score_l;
    logic [SCOREW-1:0] r_score_r;
    logic              r_serve_r;
    logic              r_winner_r;
    logic [3:0]        r_count;
    logic              r_attract;
    logic [TIMERW-1:0] w_limit;
    logic              w_done;
    logic              w_step;
    logic              w_clr;
    logic [SCOREW-1:0] w_inc_l;
    logic [SCOREW-1:0] w_inc_r;

    assign w_inc_l = (r_score_l >= W_WIN) ? r_score_l : r_score_l + SCOREW'(1);
    assign w_inc_r = (r_score_r >= W_WIN) ? r_score_r : r_score_r + SCOREW'(1);

    assign w_step = (r_state == COUNTDOWN) && w_done;
    assign w_clr  = (w_next != r_state) || w_step;

    always_comb begin
        w_limit = TIMERW'(1);
        case (r_state)
            READY:     w_limit = TIMERW'(READY_WAIT);
            COUNTDOWN: w_limit = TIMERW'(FPS);
            POINT:     w_limit = TIMERW'(POINT_WAIT);
            END_GAME:  w_limit = TIMERW'(END_WAIT);
            default:   w_limit = TIMERW'(1);
        endcase
    end

    pong_frame_timer u_timer (
        .i_clk   (clk_pix),
        .i_rst   (rst_pix),
        .i_clr   (w_clr),
        .i_frame (frame),
        .i_limit (w_limit),
        .o_done  (w_done)
    );

    // Collisions outrank pause so a point is never lost by pausing on the scoring frame.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ATTRACT:   if (sig_fire) w_next = NEW_GAME;
            NEW_GAME:  w_next = POSITION;
            POSITION:  w_next = READY;
            READY:     if (sig_fire || w_done) w_next = COUNTDOWN;
            COUNTDOWN: if (w_step && (r_count <= 4'd1)) w_next = PLAY;
            PLAY: begin
                if (coll_l) begin
                    w_next = (w_inc_r == W_WIN) ? END_GAME : POINT;
                end else if (coll_r) begin
                    w_next = (w_inc_l == W_WIN) ? END_GAME : POINT;
                end else if (sig_pause) begin
                    w_next = PAUSE;
                end
            end
            PAUSE:     if (sig_pause) w_next = PLAY;
            POINT:     if (sig_fire || w_done) w_next = POSITION;
            END_GAME: begin
                if (sig_fire) begin
                    w_next = NEW_GAME;
                end else if (w_done) begin
                    w_next = ATTRACT;
                end
            end
            default:   w_next = ATTRACT;
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_state    <= ATTRACT;
            r_score_l  <= '0;
            r_score_r  <= '0;
            r_serve_r  <= 1'b0;
            r_winner_r <= 1'b0;
            r_count    <= '0;
            r_attract  <= 1'b1;
        end else begin
            r_state   <= w_next;
            r_attract <= (w_next == ATTRACT);

            if (r_state == NEW_GAME) begin
                r_score_l  <= '0;
                r_score_r  <= '0;
                r_serve_r  <= 1'b0;
                r_winner_r <= 1'b0;
            end else if (r_state == PLAY) begin
                if (coll_l) begin
                    r_score_r <= w_inc_r;
                    r_serve_r <= 1'b0;
                    if (w_inc_r == W_WIN) r_winner_r <= 1'b1;
                end else if (coll_r) begin
                    r_score_l <= w_inc_l;
                    r_serve_r <= 1'b1;
                    if (w_inc_l == W_WIN) r_winner_r <= 1'b0;
                end
            end

            // The digit is loaded as READY hands over and only counts down inside COUNTDOWN.
            if ((r_state == READY) && (w_next == COUNTDOWN)) begin
                r_count <= 4'(COUNT_SEC);
            end else if (w_step) begin
                r_count <= r_count - 4'd1;
            end else if (r_state != COUNTDOWN) begin
                r_count <= '0;
            end
        end
    end

    assign state    = r_state;
    assign score_l  = r_score_l;
    assign score_r  = r_score_r;
    assign serve_r  = r_serve_r;
    assign winner_r = r_winner_r;
    assign count    = r_count;
    assign attract  = r_attract;
    assign pos_stb  = (r_state == POSITION);
    assign play_en  = (r_state == PLAY);

endmodule
